voice_allocator: RTL and testbench

- Polyphonic voice allocator directly downstream of the MIDI interpreter.
- Consumes single-cycle note_on/note_off pulses with the accompanying note number and frequency word.
- Assigns each note to one of NUM_VOICES oscillator/envelope slots and drives per-voice gate, retrigger, note and frequency registers to the voice bank.
- When all voices are busy, steals the oldest voice.

---
 rtl/voice_allocator.sv | 141 ++++++++++++++
 tb/tb_voice_allocator.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note on/off pulses onto voice slots,
// retriggering held notes and stealing the oldest voice when all are busy.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int FREQ_W     = 32,
  parameter int AGE_W      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           note_on,
  input  logic                           note_off,
  input  logic [6:0]                     note_in,
  input  logic [FREQ_W-1:0]              freq_in,
  output logic [NUM_VOICES-1:0]          voice_gate,
  output logic [NUM_VOICES-1:0]          voice_trig,
  output logic [7*NUM_VOICES-1:0]        voice_note,
  output logic [FREQ_W*NUM_VOICES-1:0]   voice_freq,
  output logic                           steal,
  output logic [$clog2(NUM_VOICES+1)-1:0] active_count
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CW = $clog2(NUM_VOICES+1);
  localparam logic [AGE_W-1:0] AMAX = AGE_W'(NUM_VOICES-1);

  logic [NUM_VOICES-1:0] r_gate, r_trig;
  logic [6:0]            r_note [NUM_VOICES];
  logic [FREQ_W-1:0]     r_freq [NUM_VOICES];
  logic [AGE_W-1:0]      r_age  [NUM_VOICES];
  logic                  r_steal;
  logic [CW-1:0]         r_count;

  logic [NUM_VOICES-1:0] w_gate, w_trig;
  logic [6:0]            w_note [NUM_VOICES];
  logic [FREQ_W-1:0]     w_freq [NUM_VOICES];
  logic [AGE_W-1:0]      w_age  [NUM_VOICES];
  logic                  w_steal;
  logic [CW-1:0]         w_count;

  logic          w_hit, w_free;
  logic [IW-1:0] w_hit_idx, w_free_idx, w_old_idx;

  // Lowest-index match wins, so scan from the top down.
  always_comb begin
    w_hit      = 1'b0;
    w_free     = 1'b0;
    w_hit_idx  = '0;
    w_free_idx = '0;
    w_old_idx  = '0;
    for (int v = NUM_VOICES-1; v >= 0; v--) begin
      if (r_gate[v] && r_note[v] == note_in) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(v);
      end
      if (!r_gate[v]) begin
        w_free     = 1'b1;
        w_free_idx = IW'(v);
      end
      if (r_age[v] == AMAX)
        w_old_idx = IW'(v);
    end
  end

  always_comb begin
    w_gate  = r_gate;
    w_note  = r_note;
    w_freq  = r_freq;
    w_age   = r_age;
    w_trig  = '0;
    w_steal = 1'b0;
    w_count = '0;
    if (note_on) begin
      if (w_hit) begin
        for (int v = 0; v < NUM_VOICES; v++)
          if (r_gate[v] && r_age[v] < r_age[w_hit_idx])
            w_age[v] = r_age[v] + 1'b1;
        w_age[w_hit_idx]  = '0;
        w_freq[w_hit_idx] = freq_in;
        w_trig[w_hit_idx] = 1'b1;
      end else if (w_free) begin
        for (int v = 0; v < NUM_VOICES; v++)
          if (r_gate[v] && r_age[v] != AMAX)
            w_age[v] = r_age[v] + 1'b1;
        w_gate[w_free_idx] = 1'b1;
        w_note[w_free_idx] = note_in;
        w_freq[w_free_idx] = freq_in;
        w_trig[w_free_idx] = 1'b1;
        w_age[w_free_idx]  = '0;
      end else begin
        for (int v = 0; v < NUM_VOICES; v++)
          if (r_age[v] != AMAX)
            w_age[v] = r_age[v] + 1'b1;
        w_note[w_old_idx] = note_in;
        w_freq[w_old_idx] = freq_in;
        w_trig[w_old_idx] = 1'b1;
        w_age[w_old_idx]  = '0;
        w_steal           = 1'b1;
      end
    end else if (note_off && w_hit) begin
      for (int v = 0; v < NUM_VOICES; v++)
        if (r_gate[v] && r_age[v] > r_age[w_hit_idx])
          w_age[v] = r_age[v] - 1'b1;
      w_gate[w_hit_idx] = 1'b0;
    end
    for (int v = 0; v < NUM_VOICES; v++)
      w_count = w_count + CW'(w_gate[v]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gate  <= '0;
      r_trig  <= '0;
      r_steal <= 1'b0;
      r_count <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_note[v] <= '0;
        r_freq[v] <= '0;
        r_age[v]  <= '0;
      end
    end else begin
      r_gate  <= w_gate;
      r_trig  <= w_trig;
      r_steal <= w_steal;
      r_count <= w_count;
      r_note  <= w_note;
      r_freq  <= w_freq;
      r_age   <= w_age;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note[7*g +: 7]           = r_note[g];
    assign voice_freq[FREQ_W*g +: FREQ_W] = r_freq[g];
  end

  assign voice_gate   = r_gate;
  assign voice_trig   = r_trig;
  assign steal        = r_steal;
  assign active_count = r_count;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation, retrigger, steal,
// release and reset behaviour with hand-computed expectations.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        note_on = 1'b0;
  logic        note_off = 1'b0;
  logic [6:0]  note_in = '0;
  logic [31:0] freq_in = '0;
  logic [3:0]  voice_gate, voice_trig;
  logic [27:0] voice_note;
  logic [127:0] voice_freq;
  logic        steal;
  logic [2:0]  active_count;

  int n_cmp = 0;
  int n_bad = 0;

  voice_allocator #(.NUM_VOICES(4), .FREQ_W(32), .AGE_W(4)) dut (
    .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off),
    .note_in(note_in), .freq_in(freq_in), .voice_gate(voice_gate),
    .voice_trig(voice_trig), .voice_note(voice_note),
    .voice_freq(voice_freq), .steal(steal), .active_count(active_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] vn(input int v);
    return voice_note[7*v +: 7];
  endfunction

  function automatic logic [31:0] vf(input int v);
    return voice_freq[32*v +: 32];
  endfunction

  // Drive one event for one cycle; returns at the next negedge, when
  // the registered outputs already reflect it.
  task automatic send(input logic on, input logic off,
                      input logic [6:0] n, input logic [31:0] f);
    note_on  = on;
    note_off = off;
    note_in  = n;
    freq_in  = f;
    @(negedge clk);
    note_on  = 1'b0;
    note_off = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_gate", 64'(voice_gate), 64'h0);
    chk("rst_trig", 64'(voice_trig), 64'h0);
    chk("rst_steal", 64'(steal), 64'h0);
    chk("rst_count", 64'(active_count), 64'h0);
    chk("rst_note", 64'(voice_note), 64'h0);

    // Three notes back-to-back
    send(1, 0, 7'd60, 32'd261);
    chk("t1_trig0", 64'(voice_trig), 64'h1);
    send(1, 0, 7'd64, 32'd293);
    chk("t1_trig1", 64'(voice_trig), 64'h2);
    send(1, 0, 7'd67, 32'd329);
    chk("t1_trig2", 64'(voice_trig), 64'h4);
    chk("t1_gate", 64'(voice_gate), 64'h7);
    chk("t1_count", 64'(active_count), 64'd3);
    chk("t1_n0", 64'(vn(0)), 64'd60);
    chk("t1_n1", 64'(vn(1)), 64'd64);
    chk("t1_n2", 64'(vn(2)), 64'd67);
    chk("t1_f0", 64'(vf(0)), 64'd261);
    idle();
    chk("t1_trig_clr", 64'(voice_trig), 64'h0);

    // Steal oldest when full
    do_reset();
    send(1, 0, 7'd60, 32'd100);
    send(1, 0, 7'd62, 32'd101);
    send(1, 0, 7'd64, 32'd102);
    send(1, 0, 7'd65, 32'd103);
    chk("t2_full", 64'(voice_gate), 64'hf);
    chk("t2_steal0", 64'(steal), 64'h0);
    send(1, 0, 7'd67, 32'd104);
    chk("t2_steal", 64'(steal), 64'h1);
    chk("t2_trig", 64'(voice_trig), 64'h1);
    chk("t2_gate", 64'(voice_gate), 64'hf);
    chk("t2_n0", 64'(vn(0)), 64'd67);
    chk("t2_f0", 64'(vf(0)), 64'd104);
    idle();
    chk("t2_steal_clr", 64'(steal), 64'h0);
    chk("t2_trig_clr", 64'(voice_trig), 64'h0);
    send(0, 1, 7'd60, 32'd0);
    chk("t2_off_gate", 64'(voice_gate), 64'hf);
    chk("t2_off_count", 64'(active_count), 64'd4);
    chk("t2_off_n0", 64'(vn(0)), 64'd67);

    // Release then reuse of the freed slot
    do_reset();
    send(1, 0, 7'd60, 32'd1);
    send(1, 0, 7'd62, 32'd2);
    send(1, 0, 7'd64, 32'd3);
    send(0, 1, 7'd62, 32'd0);
    chk("t3_gate", 64'(voice_gate), 64'h5);
    chk("t3_count", 64'(active_count), 64'd2);
    chk("t3_n1_hold", 64'(vn(1)), 64'd62);
    chk("t3_f1_hold", 64'(vf(1)), 64'd2);
    chk("t3_trig_off", 64'(voice_trig), 64'h0);
    send(1, 0, 7'd69, 32'd9);
    chk("t3_trig", 64'(voice_trig), 64'h2);
    chk("t3_gate2", 64'(voice_gate), 64'h7);
    chk("t3_n1", 64'(vn(1)), 64'd69);

    // Retrigger keeps ages consistent for later steals
    do_reset();
    send(1, 0, 7'd60, 32'd10);
    send(1, 0, 7'd64, 32'd11);
    send(1, 0, 7'd67, 32'd12);
    send(1, 0, 7'd71, 32'd13);
    // ages now v0=3 v1=2 v2=1 v3=0
    send(1, 0, 7'd64, 32'd330);
    // ages v0=3 v1=0 v2=2 v3=1
    chk("t4_trig", 64'(voice_trig), 64'h2);
    chk("t4_steal", 64'(steal), 64'h0);
    chk("t4_count", 64'(active_count), 64'd4);
    chk("t4_f1", 64'(vf(1)), 64'd330);
    send(1, 0, 7'd72, 32'd14);
    // ages v0=0 v1=1 v2=3 v3=2
    chk("t4_st1_trig", 64'(voice_trig), 64'h1);
    chk("t4_st1_steal", 64'(steal), 64'h1);
    send(1, 0, 7'd74, 32'd15);
    chk("t4_st2_trig", 64'(voice_trig), 64'h4);
    chk("t4_st2_n2", 64'(vn(2)), 64'd74);
    // ages v0=1 v1=2 v2=0 v3=3; release v1 then steal-free slot
    send(0, 1, 7'd64, 32'd0);
    chk("t4_rel_gate", 64'(voice_gate), 64'hd);
    send(1, 0, 7'd76, 32'd16);
    chk("t4_reuse", 64'(voice_trig), 64'h2);
    // ages v0=2 v1=0 v2=1 v3=3 after release/refill
    send(1, 0, 7'd77, 32'd17);
    chk("t4_st3_trig", 64'(voice_trig), 64'h8);

    // Simultaneous on/off, then off of an unheld note
    do_reset();
    send(1, 1, 7'd72, 32'd500);
    chk("t5_gate", 64'(voice_gate), 64'h1);
    chk("t5_trig", 64'(voice_trig), 64'h1);
    chk("t5_n0", 64'(vn(0)), 64'd72);
    send(0, 1, 7'd50, 32'd0);
    chk("t5_off_gate", 64'(voice_gate), 64'h1);
    chk("t5_off_trig", 64'(voice_trig), 64'h0);
    chk("t5_off_steal", 64'(steal), 64'h0);
    chk("t5_off_count", 64'(active_count), 64'd1);
    chk("t5_off_n0", 64'(vn(0)), 64'd72);

    // Reset wins over a coincident note_on
    do_reset();
    send(1, 0, 7'd60, 32'd1);
    send(1, 0, 7'd62, 32'd2);
    send(1, 0, 7'd64, 32'd3);
    rst = 1'b1;
    send(1, 0, 7'd70, 32'd7);
    rst = 1'b0;
    chk("t6_gate", 64'(voice_gate), 64'h0);
    chk("t6_trig", 64'(voice_trig), 64'h0);
    chk("t6_steal", 64'(steal), 64'h0);
    chk("t6_count", 64'(active_count), 64'd0);
    send(1, 0, 7'd75, 32'd8);
    chk("t6_trig2", 64'(voice_trig), 64'h1);
    chk("t6_gate2", 64'(voice_gate), 64'h1);
    chk("t6_n0", 64'(vn(0)), 64'd75);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
